// File: rtl/audio_pkg.sv
// Shared types and constants for the codec capture path.
// Included by the synchronizer and the capture top.
package audio_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_BITS  = 20;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_LEFT,
    S_RIGHT,
    S_WRITE,
    S_TAIL
  } state_t;

  typedef struct packed {
    logic q;
    logic rise;
    logic fall;
  } edge_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer plus edge detect for one codec line.
// q is the synchronized level; rise/fall compare it to a delayed copy.
module sync_edge
  import audio_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  d,
  output edge_t e
);

  logic [2:0] sh_q;
  logic [2:0] sh_d;

  always_comb begin
    sh_d = {sh_q[1:0], d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

  assign e = {sh_q[1],
              sh_q[1] & ~sh_q[2],
              ~sh_q[1] & sh_q[2]};

endmodule

// File: rtl/audio_capture.sv
// I2S stereo capture into a linear memory, one write per L/R pair.
// All codec lines are resynchronized into Clk before use.
module audio_capture
  import audio_pkg::*;
#(
  parameter int                   DATA_W   = DATA_W_DEF,
  parameter logic [ADDR_BITS-1:0] ADDR_MAX = 20'hFFFFF,
  parameter logic                 WRAP     = 1'b0
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  AUD_BCLK,
  input  logic                  AUD_ADCLRCK,
  input  logic                  AUD_ADCDAT,
  input  logic                  start,
  input  logic                  stop,
  output logic [DATA_W-1:0]     LDATA,
  output logic [DATA_W-1:0]     RDATA,
  output logic                  sample_valid,
  output logic                  WE,
  output logic [ADDR_BITS-1:0]  ADDR_W,
  output logic [2*DATA_W-1:0]   Data_In,
  output logic                  busy,
  output logic                  full
);

  localparam logic [DATA_W:0] P_SKIP = {1'b1, {DATA_W{1'b0}}};
  localparam logic [DATA_W:0] P_MSB  = P_SKIP >> 1;

  edge_t bc_e;
  edge_t lr_e;
  edge_t dat_e;
  logic  dat_unused;

  sync_edge u_bclk (.clk(Clk), .rst(Reset), .d(AUD_BCLK),    .e(bc_e));
  sync_edge u_lrck (.clk(Clk), .rst(Reset), .d(AUD_ADCLRCK), .e(lr_e));
  sync_edge u_dat  (.clk(Clk), .rst(Reset), .d(AUD_ADCDAT),  .e(dat_e));

  assign dat_unused = dat_e.rise | dat_e.fall;

  state_t               state_q, state_d;
  logic [DATA_W-1:0]    lsh_q, lsh_d;
  logic [DATA_W-1:0]    rsh_q, rsh_d;
  logic [DATA_W:0]      pos_q, pos_d;
  logic                 cls_q, cls_d;
  logic [DATA_W-1:0]    ldata_q, ldata_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic [2*DATA_W-1:0]  din_q, din_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 we_q, we_d;
  logic                 sv_q, sv_d;
  logic                 busy_q, busy_d;
  logic                 full_q, full_d;

  logic [DATA_W:0]      pos_init;
  logic [DATA_W-1:0]    dmask;

  // pos is a one-hot bit slot: top bit is the I2S delay slot, then MSB..LSB
  assign pos_init = bc_e.rise ? P_MSB : P_SKIP;
  assign dmask    = {DATA_W{dat_e.q}} & pos_q[DATA_W-1:0];

  always_comb begin
    state_d = state_q;
    lsh_d   = lsh_q;
    rsh_d   = rsh_q;
    pos_d   = pos_q;
    cls_d   = cls_q;
    ldata_d = ldata_q;
    rdata_d = rdata_q;
    din_d   = din_q;
    addr_d  = addr_q;
    full_d  = full_q;
    we_d    = 1'b0;
    sv_d    = 1'b0;
    busy_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && !full_q) state_d = S_ARM;
      end
      S_ARM: begin
        if (lr_e.fall) begin
          state_d = S_LEFT;
          lsh_d   = '0;
          pos_d   = pos_init;
        end
      end
      S_LEFT: begin
        if (lr_e.rise) begin
          state_d = S_RIGHT;
          rsh_d   = '0;
          pos_d   = pos_init;
        end else if (bc_e.rise) begin
          lsh_d = lsh_q | dmask;
          pos_d = pos_q >> 1;
        end
      end
      S_RIGHT: begin
        if (lr_e.fall) begin
          state_d = S_WRITE;
          cls_d   = 1'b1;
          lsh_d   = '0;
          pos_d   = pos_init;
        end else if (bc_e.rise) begin
          rsh_d = rsh_q | dmask;
          pos_d = pos_q >> 1;
          if (pos_q[0]) begin
            state_d = S_WRITE;
            cls_d   = 1'b0;
          end
        end
      end
      S_WRITE: begin
        if (addr_q == ADDR_MAX) begin
          addr_d = WRAP ? '0 : addr_q;
        end else begin
          addr_d = addr_q + 1'b1;
        end
        if (addr_q == ADDR_MAX && !WRAP) begin
          full_d  = 1'b1;
          state_d = S_IDLE;
        end else if (cls_q) begin
          state_d = S_LEFT;
          if (bc_e.rise) begin
            lsh_d = lsh_q | dmask;
            pos_d = pos_q >> 1;
          end
        end else if (lr_e.fall) begin
          state_d = S_LEFT;
          lsh_d   = '0;
          pos_d   = pos_init;
        end else begin
          state_d = S_TAIL;
        end
      end
      S_TAIL: begin
        if (lr_e.fall) begin
          state_d = S_LEFT;
          lsh_d   = '0;
          pos_d   = pos_init;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (stop) state_d = S_IDLE;
    if (state_d == S_WRITE) begin
      we_d    = 1'b1;
      sv_d    = 1'b1;
      ldata_d = lsh_q;
      rdata_d = rsh_d;
      din_d   = {lsh_q, rsh_d};
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      lsh_q   <= '0;
      rsh_q   <= '0;
      pos_q   <= '0;
      cls_q   <= 1'b0;
      ldata_q <= '0;
      rdata_q <= '0;
      din_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      sv_q    <= 1'b0;
      busy_q  <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lsh_q   <= lsh_d;
      rsh_q   <= rsh_d;
      pos_q   <= pos_d;
      cls_q   <= cls_d;
      ldata_q <= ldata_d;
      rdata_q <= rdata_d;
      din_q   <= din_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      sv_q    <= sv_d;
      busy_q  <= busy_d;
      full_q  <= full_d;
    end
  end

  assign LDATA        = ldata_q;
  assign RDATA        = rdata_q;
  assign Data_In      = din_q;
  assign ADDR_W       = addr_q;
  assign WE           = we_q;
  assign sample_valid = sv_q;
  assign busy         = busy_q;
  assign full         = full_q;

endmodule

// File: tb/tb_audio_capture.sv
// Directed/random I2S capture bench with a word/address reference model.
// Two instances: ADDR_MAX=3 without and with address wrap.
module tb_audio_capture;

  logic clk = 1'b0;
  logic bclk = 1'b0;
  logic reset = 1'b1;
  logic lrck = 1'b1;
  logic dat = 1'b0;
  logic start = 1'b0;
  logic stop = 1'b0;

  logic [15:0] ld0, rd0, ld1, rd1;
  logic [31:0] din0, din1;
  logic [19:0] a0, a1;
  logic        we0, sv0, busy0, full0;
  logic        we1, sv1, busy1, full1;

  always #5 clk = ~clk;
  always #39 bclk = ~bclk;

  audio_capture #(.DATA_W(16), .ADDR_MAX(20'd3), .WRAP(1'b0)) u0 (
    .Clk(clk), .Reset(reset), .AUD_BCLK(bclk), .AUD_ADCLRCK(lrck),
    .AUD_ADCDAT(dat), .start(start), .stop(stop), .LDATA(ld0),
    .RDATA(rd0), .sample_valid(sv0), .WE(we0), .ADDR_W(a0),
    .Data_In(din0), .busy(busy0), .full(full0));

  audio_capture #(.DATA_W(16), .ADDR_MAX(20'd3), .WRAP(1'b1)) u1 (
    .Clk(clk), .Reset(reset), .AUD_BCLK(bclk), .AUD_ADCLRCK(lrck),
    .AUD_ADCDAT(dat), .start(start), .stop(stop), .LDATA(ld1),
    .RDATA(rd1), .sample_valid(sv1), .WE(we1), .ADDR_W(a1),
    .Data_In(din1), .busy(busy1), .full(full1));

  typedef struct packed {
    logic [19:0] a;
    logic [31:0] d;
    logic [15:0] l;
    logic [15:0] r;
  } wr_t;

  wr_t q0[$];
  wr_t q1[$];
  int  sv_bad = 0;
  int  total = 0;
  int  bad = 0;

  always @(negedge clk) begin
    if (we0 === 1'b1) q0.push_back(wr_t'{a0, din0, ld0, rd0});
    if (we1 === 1'b1) q1.push_back(wr_t'{a1, din1, ld1, rd1});
    if (sv0 !== we0 || sv1 !== we1) sv_bad++;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] trunc(input logic [15:0] w,
                                        input int n);
    logic [15:0] m;
    m = 16'hFFFF << (16 - n);
    return w & m;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_data"}, {din0, ld0, rd0}, 64'd0);
    chk({tag, "_ctl"}, {a0, we0, sv0, busy0, full0}, 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    q0.delete();
    q1.delete();
    repeat (4) @(negedge clk);
  endtask

  // kind: 0 start, 1 stop, 2 start+stop, 3 reset pulse
  task automatic act(input int kind);
    @(negedge clk);
    if (kind == 3) begin
      reset = 1'b1;
      @(negedge clk);
      chk_zero("mid_rst");
      reset = 1'b0;
    end else begin
      start = (kind == 0 || kind == 2);
      stop  = (kind == 1 || kind == 2);
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r,
                            input int nl, input int nr, input int slot,
                            input int act_ch, input int act_k,
                            input int act_kind);
    for (int ch = 0; ch < 2; ch++) begin
      logic [15:0] cur;
      int n;
      cur = (ch == 1) ? r : l;
      n   = (ch == 1) ? nr : nl;
      for (int k = 0; k < slot; k++) begin
        @(negedge bclk);
        if (k == 0) lrck = (ch == 1);
        if (k >= 1 && k <= n) begin
          dat = cur[15];
          cur = cur << 1;
        end else begin
          dat = 1'b0;
        end
        if (act_ch == ch + 1 && act_k == k) act(act_kind);
      end
    end
  endtask

  task automatic settle();
    repeat (3) @(negedge bclk);
    @(negedge clk);
  endtask

  logic [15:0] fl[5];
  logic [15:0] fr[5];
  logic [31:0] expd[$];

  initial begin
    // Group A: reset state, known pair, continuous capture, stop
    do_reset();
    chk_zero("reset");
    act(0);
    chk("arm_busy", {63'd0, busy0}, 64'd1);
    send_frame(16'hA5C3, 16'h3C5A, 16, 16, 18, 0, 0, 0);
    settle();
    chk("a_we_cnt1", q0.size(), 1);
    if (q0.size() >= 1) begin
      chk("a_din", q0[0].d, 32'hA5C33C5A);
      chk("a_addr", q0[0].a, 0);
    end
    chk("a_addr_next", a0, 1);
    expd.delete();
    for (int i = 0; i < 2; i++) begin
      fl[i] = 16'($urandom);
      fr[i] = 16'($urandom);
      expd.push_back({fl[i], fr[i]});
      send_frame(fl[i], fr[i], 16, 16, 17 + i, 0, 0, 0);
    end
    settle();
    chk("a_we_cnt3", q0.size(), 3);
    for (int i = 0; i < 2; i++) begin
      if (q0.size() > i + 1) begin
        chk("a_rnd_din", q0[i + 1].d, expd[i]);
        chk("a_rnd_addr", q0[i + 1].a, i + 1);
        chk("a_rnd_ld", q0[i + 1].l, expd[i][31:16]);
        chk("a_rnd_rd", q0[i + 1].r, expd[i][15:0]);
      end
    end
    act(1);
    chk("a_stop_ctl", {a0, busy0, full0}, {20'd3, 2'b00});

    // Group B: arm mid-right frame, short words, stop mid-left
    do_reset();
    fl[0] = 16'($urandom);
    fr[0] = 16'($urandom);
    fl[1] = 16'($urandom);
    fr[1] = 16'($urandom);
    send_frame(fl[0], fr[0], 16, 16, 18, 2, 5, 0);
    chk("b_no_we", q0.size(), 0);
    chk("b_armed", {63'd0, busy0}, 64'd1);
    send_frame(fl[1], fr[1], 16, 16, 18, 0, 0, 0);
    settle();
    chk("b_we_cnt", q0.size(), 1);
    if (q0.size() >= 1) chk("b_next_pair", q0[0].d, {fl[1], fr[1]});
    send_frame(16'hFFFF, 16'hFFFF, 12, 12, 13, 0, 0, 0);
    send_frame(16'($urandom), 16'($urandom), 16, 16, 18, 1, 11, 1);
    settle();
    chk("b_short_cnt", q0.size(), 2);
    if (q0.size() >= 2) begin
      chk("b_short_din", q0[1].d,
          {trunc(16'hFFFF, 12), trunc(16'hFFFF, 12)});
      chk("b_short_addr", q0[1].a, 1);
    end
    chk("b_short_lr", {ld0, rd0}, 32'hFFF0FFF0);
    chk("b_stop_ctl", {a0, busy0}, {20'd2, 1'b0});
    act(2);
    repeat (3) @(negedge clk);
    chk("b_ss_idle", {63'd0, busy0}, 64'd0);
    send_frame(16'($urandom), 16'($urandom), 16, 16, 18, 0, 0, 0);
    settle();
    chk("b_ss_no_we", q0.size(), 2);
    chk("b_ss_addr", a0, 2);

    // Group C: reset during right channel
    do_reset();
    act(0);
    send_frame(16'($urandom), 16'($urandom), 16, 16, 18, 0, 0, 0);
    settle();
    chk("c_pre_cnt", q0.size(), 1);
    q0.delete();
    send_frame(16'($urandom), 16'($urandom), 16, 16, 18, 2, 6, 3);
    settle();
    chk("c_no_we", q0.size(), 0);
    chk("c_idle", {a0, busy0}, 21'd0);

    // Group D: fill to ADDR_MAX, with and without wrap
    do_reset();
    act(0);
    expd.delete();
    for (int i = 0; i < 5; i++) begin
      fl[i] = 16'($urandom);
      fr[i] = 16'($urandom);
      expd.push_back({fl[i], fr[i]});
      send_frame(fl[i], fr[i], 16, 16, 18, 0, 0, 0);
    end
    settle();
    chk("d_cnt_nowrap", q0.size(), 4);
    chk("d_cnt_wrap", q1.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < 4 && q0.size() > i) begin
        chk("d_din0", q0[i].d, expd[i]);
        chk("d_addr0", q0[i].a, i);
      end
      if (q1.size() > i) begin
        chk("d_din1", q1[i].d, expd[i]);
        chk("d_addr1", q1[i].a, i % 4);
      end
    end
    chk("d_full0", {a0, busy0, full0}, {20'd3, 2'b01});
    chk("d_run1", {a1, busy1, full1}, {20'd1, 2'b10});
    act(0);
    repeat (3) @(negedge clk);
    chk("d_start_full", {62'd0, busy0, full0}, 64'd1);

    chk("sv_eq_we", sv_bad, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
